// File: rtl/cc_speed_ticker_if.sv
// Control/handshake bundle between game control, the speed ticker and the
// lane logic that consumes movement steps.
interface cc_speed_ticker_if #(
    parameter int DATAWIDTH  = 23,
    parameter int LEVELWIDTH = 3
);
    logic                  CC_SPEEDTICKER_start_In;
    logic                  CC_SPEEDTICKER_pause_In;
    logic                  CC_SPEEDTICKER_restart_In;
    logic                  CC_SPEEDTICKER_levelUp_In;
    logic                  CC_SPEEDTICKER_stepAck_In;
    logic [DATAWIDTH-1:0]  CC_SPEEDTICKER_data_OutBUS;
    logic [LEVELWIDTH-1:0] CC_SPEEDTICKER_CurrentLevel_OutBUS;
    logic                  CC_SPEEDTICKER_T0_OutLow;
    logic                  CC_SPEEDTICKER_stepValid_Out;
    logic [1:0]            CC_SPEEDTICKER_pending_OutBUS;
    logic [1:0]            CC_SPEEDTICKER_state_OutBUS;

    // Game control / lane consumer side.
    modport master (
        output CC_SPEEDTICKER_start_In,
        output CC_SPEEDTICKER_pause_In,
        output CC_SPEEDTICKER_restart_In,
        output CC_SPEEDTICKER_levelUp_In,
        output CC_SPEEDTICKER_stepAck_In,
        input  CC_SPEEDTICKER_data_OutBUS,
        input  CC_SPEEDTICKER_CurrentLevel_OutBUS,
        input  CC_SPEEDTICKER_T0_OutLow,
        input  CC_SPEEDTICKER_stepValid_Out,
        input  CC_SPEEDTICKER_pending_OutBUS,
        input  CC_SPEEDTICKER_state_OutBUS
    );

    // Speed ticker side.
    modport slave (
        input  CC_SPEEDTICKER_start_In,
        input  CC_SPEEDTICKER_pause_In,
        input  CC_SPEEDTICKER_restart_In,
        input  CC_SPEEDTICKER_levelUp_In,
        input  CC_SPEEDTICKER_stepAck_In,
        output CC_SPEEDTICKER_data_OutBUS,
        output CC_SPEEDTICKER_CurrentLevel_OutBUS,
        output CC_SPEEDTICKER_T0_OutLow,
        output CC_SPEEDTICKER_stepValid_Out,
        output CC_SPEEDTICKER_pending_OutBUS,
        output CC_SPEEDTICKER_state_OutBUS
    );
endinterface

// File: rtl/cc_speed_ticker.sv
// Speed ticker: free-running speed counter, current level register and the
// per-level movement tick, plus a small saturating queue of pending steps
// handed to the lane shifters over a valid/ack handshake.
module cc_speed_ticker #(
    parameter int DATAWIDTH  = 23,
    parameter int LEVELWIDTH = 3,
    parameter int TC_L2      = 8480,
    parameter int TC_L4      = 4384,
    parameter int TC_L6      = 2336
) (
    input  logic              CC_SPEEDTICKER_CLOCK_50,
    input  logic              CC_SPEEDTICKER_RESET_InLow,
    cc_speed_ticker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [LEVELWIDTH-1:0] LVL2 = LEVELWIDTH'(2);
    localparam logic [LEVELWIDTH-1:0] LVL4 = LEVELWIDTH'(4);
    localparam logic [LEVELWIDTH-1:0] LVL6 = LEVELWIDTH'(6);

    state_t                state_q,   state_d;
    logic [DATAWIDTH-1:0]  count_q,   count_d;
    logic [LEVELWIDTH-1:0] level_q,   level_d;
    logic                  tick_q,    tick_d;
    logic [1:0]            pending_q, pending_d;
    logic [DATAWIDTH-1:0]  tc;
    logic                  step_inc;
    logic                  step_dec;

    // Terminal count for the current level; unknown levels fall back to the slowest speed.
    always_comb begin
        case (level_q)
            LVL4:    tc = DATAWIDTH'(TC_L4);
            LVL6:    tc = DATAWIDTH'(TC_L6);
            default: tc = DATAWIDTH'(TC_L2);
        endcase
    end

    // Next-state logic for FSM, speed counter, tick and level; restart overrides everything.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        tick_d  = 1'b0;
        if (bus.CC_SPEEDTICKER_restart_In) begin
            state_d = ST_IDLE;
            count_d = '0;
            level_d = LVL2;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (bus.CC_SPEEDTICKER_start_In) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // >= so a level-up that drops TC below the count ticks promptly.
                    if (count_q >= tc) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (bus.CC_SPEEDTICKER_pause_In) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (!bus.CC_SPEEDTICKER_pause_In) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
            // Level only advances while a game is in progress; saturates at 6.
            if (bus.CC_SPEEDTICKER_levelUp_In && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
                level_d = (level_q == LVL2) ? LVL4 : LVL6;
            end
        end
    end

    assign step_inc = tick_d;
    assign step_dec = bus.CC_SPEEDTICKER_stepAck_In && (pending_q != 2'd0);

    // Saturating pending-step count; a tick arriving with the queue full is dropped.
    always_comb begin
        pending_d = pending_q;
        if (bus.CC_SPEEDTICKER_restart_In) begin
            pending_d = 2'd0;
        end else begin
            case ({step_inc, step_dec})
                2'b10:   if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
                2'b01:   pending_d = pending_q - 2'd1;
                default: pending_d = pending_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CC_SPEEDTICKER_CLOCK_50 or negedge CC_SPEEDTICKER_RESET_InLow) begin
        if (!CC_SPEEDTICKER_RESET_InLow) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            level_q   <= LVL2;
            tick_q    <= 1'b0;
            pending_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign bus.CC_SPEEDTICKER_data_OutBUS         = count_q;
    assign bus.CC_SPEEDTICKER_CurrentLevel_OutBUS = level_q;
    assign bus.CC_SPEEDTICKER_T0_OutLow           = ~tick_q;
    assign bus.CC_SPEEDTICKER_stepValid_Out       = (pending_q != 2'd0);
    assign bus.CC_SPEEDTICKER_pending_OutBUS      = pending_q;
    assign bus.CC_SPEEDTICKER_state_OutBUS        = state_q;

endmodule

// File: tb/tb_cc_speed_ticker.sv
// Directed bench for cc_speed_ticker: reset, per-level tick timing, level-up
// with the >= compare, pause hold, pending saturation and restart priority.
module tb_cc_speed_ticker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   low_seen;

    always #5 clk = ~clk;

    cc_speed_ticker_if #(.DATAWIDTH(23), .LEVELWIDTH(3)) bus ();

    cc_speed_ticker dut (
        .CC_SPEEDTICKER_CLOCK_50    (clk),
        .CC_SPEEDTICKER_RESET_InLow (rst_n),
        .bus                        (bus.slave)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input int st, input int data, input int lvl,
                             input int t0, input int pend, input int vld);
        check({tag, ".state"},   32'(bus.CC_SPEEDTICKER_state_OutBUS),        32'(st));
        check({tag, ".data"},    32'(bus.CC_SPEEDTICKER_data_OutBUS),         32'(data));
        check({tag, ".level"},   32'(bus.CC_SPEEDTICKER_CurrentLevel_OutBUS), 32'(lvl));
        check({tag, ".t0"},      32'(bus.CC_SPEEDTICKER_T0_OutLow),           32'(t0));
        check({tag, ".pending"}, 32'(bus.CC_SPEEDTICKER_pending_OutBUS),      32'(pend));
        check({tag, ".valid"},   32'(bus.CC_SPEEDTICKER_stepValid_Out),       32'(vld));
        $display("step %-14s state=%0d data=%0d level=%0d t0=%0d pending=%0d valid=%0d", tag,
                 bus.CC_SPEEDTICKER_state_OutBUS, bus.CC_SPEEDTICKER_data_OutBUS,
                 bus.CC_SPEEDTICKER_CurrentLevel_OutBUS, bus.CC_SPEEDTICKER_T0_OutLow,
                 bus.CC_SPEEDTICKER_pending_OutBUS, bus.CC_SPEEDTICKER_stepValid_Out);
    endtask

    initial begin
        bus.CC_SPEEDTICKER_start_In   = 1'b0;
        bus.CC_SPEEDTICKER_pause_In   = 1'b0;
        bus.CC_SPEEDTICKER_restart_In = 1'b0;
        bus.CC_SPEEDTICKER_levelUp_In = 1'b0;
        bus.CC_SPEEDTICKER_stepAck_In = 1'b0;

        // Power-on reset
        step(2);
        check_all("por", 0, 0, 2, 1, 0, 0);
        rst_n = 1'b1;
        step(1);

        // T1: run at level 4 to count 1000, then async reset mid-run
        bus.CC_SPEEDTICKER_start_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_start_In = 1'b0;
        check_all("t1_start", 1, 0, 2, 1, 0, 0);
        bus.CC_SPEEDTICKER_levelUp_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_levelUp_In = 1'b0;
        step(999);
        check_all("t1_cnt1000", 1, 1000, 4, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        check_all("t1_async", 0, 0, 2, 1, 0, 0);
        rst_n = 1'b1;
        step(1);
        check_all("t1_release", 0, 0, 2, 1, 0, 0);

        // T2: level 2 tick period of 8481 cycles
        bus.CC_SPEEDTICKER_start_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_start_In = 1'b0;
        step(8480);
        check_all("t2_pre1", 1, 8480, 2, 1, 0, 0);
        step(1);
        check_all("t2_tick1", 1, 0, 2, 0, 1, 1);
        step(1);
        check_all("t2_width", 1, 1, 2, 1, 1, 1);
        step(8479);
        check_all("t2_pre2", 1, 8480, 2, 1, 1, 1);
        step(1);
        check_all("t2_tick2", 1, 0, 2, 0, 2, 1);
        bus.CC_SPEEDTICKER_stepAck_In = 1'b1;
        step(1);
        check_all("t2_ack1", 1, 1, 2, 1, 1, 1);
        step(1);
        check_all("t2_ack2", 1, 2, 2, 1, 0, 0);
        step(1);
        check_all("t2_ack_empty", 1, 3, 2, 1, 0, 0);
        bus.CC_SPEEDTICKER_stepAck_In = 1'b0;

        // T3: level-up to 6 at count 3000 in level 4
        bus.CC_SPEEDTICKER_levelUp_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_levelUp_In = 1'b0;
        step(2996);
        check_all("t3_cnt3000", 1, 3000, 4, 1, 0, 0);
        bus.CC_SPEEDTICKER_levelUp_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_levelUp_In = 1'b0;
        check_all("t3_lvl6", 1, 3001, 6, 1, 0, 0);
        step(1);
        check_all("t3_tick", 1, 0, 6, 0, 1, 1);
        bus.CC_SPEEDTICKER_stepAck_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_stepAck_In = 1'b0;
        check_all("t3_ack", 1, 1, 6, 1, 0, 0);

        // T4: pause holding the count at 500
        step(498);
        bus.CC_SPEEDTICKER_pause_In = 1'b1;
        step(1);
        check_all("t4_pause", 2, 500, 6, 1, 0, 0);
        low_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus.CC_SPEEDTICKER_T0_OutLow !== 1'b1) low_seen++;
        end
        check("t4_no_tick", 32'(low_seen), 32'd0);
        check_all("t4_held", 2, 500, 6, 1, 0, 0);
        bus.CC_SPEEDTICKER_pause_In = 1'b0;
        step(1);
        check_all("t4_release", 1, 500, 6, 1, 0, 0);
        step(1);
        check_all("t4_resume", 1, 501, 6, 1, 0, 0);

        // T5: pending saturation at 3, tick+ack together, drain
        step(1835);
        check_all("t5_pre", 1, 2336, 6, 1, 0, 0);
        step(1);
        check_all("t5_tick1", 1, 0, 6, 0, 1, 1);
        step(2337);
        check_all("t5_tick2", 1, 0, 6, 0, 2, 1);
        step(2337);
        check_all("t5_tick3", 1, 0, 6, 0, 3, 1);
        step(2337);
        check_all("t5_tick4_sat", 1, 0, 6, 0, 3, 1);
        step(2336);
        bus.CC_SPEEDTICKER_stepAck_In = 1'b1;
        step(1);
        check_all("t5_tick_ack", 1, 0, 6, 0, 3, 1);
        step(1);
        check_all("t5_drain1", 1, 1, 6, 1, 2, 1);
        step(1);
        check_all("t5_drain2", 1, 2, 6, 1, 1, 1);
        step(1);
        check_all("t5_drain3", 1, 3, 6, 1, 0, 0);
        bus.CC_SPEEDTICKER_stepAck_In = 1'b0;

        // T6: restart priority, idle level-up ignored, level saturation
        bus.CC_SPEEDTICKER_restart_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_restart_In = 1'b0;
        check_all("t6_restart", 0, 0, 2, 1, 0, 0);
        bus.CC_SPEEDTICKER_start_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_start_In = 1'b0;
        bus.CC_SPEEDTICKER_levelUp_In = 1'b1;
        step(1);
        check_all("t6_lvl4", 1, 1, 4, 1, 0, 0);
        bus.CC_SPEEDTICKER_restart_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_restart_In = 1'b0;
        check_all("t6_rst_lvlup", 0, 0, 2, 1, 0, 0);
        step(1);
        check_all("t6_idle_lvlup", 0, 0, 2, 1, 0, 0);
        bus.CC_SPEEDTICKER_levelUp_In = 1'b0;
        bus.CC_SPEEDTICKER_start_In = 1'b1;
        step(1);
        bus.CC_SPEEDTICKER_start_In = 1'b0;
        bus.CC_SPEEDTICKER_levelUp_In = 1'b1;
        step(2);
        check_all("t6_lvl6", 1, 2, 6, 1, 0, 0);
        step(1);
        check_all("t6_lvl6_sat", 1, 3, 6, 1, 0, 0);
        bus.CC_SPEEDTICKER_levelUp_In = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
